// File: rtl/fir_16tap.sv
// 16-tap fixed-coefficient Q1.15 FIR, fully pipelined, 7-clock latency.
// FIR_SAT_EN: clamp the output to the 16-bit range, else wrap acc[30:15].
module fir_16tap (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] x_in,
  output logic signed [15:0] y_out
);

  function automatic logic signed [15:0] coef(input logic [3:0] i);
    case (i)
      4'd0:    coef = 16'sd512;
      4'd1:    coef = 16'sd1024;
      4'd2:    coef = 16'sd2048;
      4'd3:    coef = 16'sd4096;
      4'd4:    coef = 16'sd8192;
      4'd5:    coef = 16'sd4096;
      4'd6:    coef = 16'sd2048;
      4'd7:    coef = 16'sd1024;
      4'd8:    coef = 16'sd512;
      4'd9:    coef = 16'sd256;
      4'd10:   coef = 16'sd128;
      4'd11:   coef = 16'sd64;
      4'd12:   coef = 16'sd32;
      4'd13:   coef = 16'sd16;
      4'd14:   coef = 16'sd8;
      default: coef = 16'sd4;
    endcase
  endfunction

  logic signed [15:0] x_reg;
  logic signed [15:0] d  [16];
  logic signed [31:0] p  [16];
  logic signed [32:0] t1 [8];
  logic signed [33:0] t2 [4];
  logic signed [34:0] t3 [2];
  logic signed [35:0] acc;
  logic signed [15:0] y_next;

  // Input register and delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      for (int i = 0; i < 16; i++) d[i] <= '0;
    end else begin
      x_reg <= x_in;
      d[0]  <= x_reg;
      for (int i = 1; i < 16; i++) d[i] <= d[i-1];
    end
  end

  // Registered full-width tap products
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) p[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        p[i] <= 32'(d[i]) * 32'(coef(4'(i)));
    end
  end

  // Adder tree, one registered level per halving
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) t1[i] <= '0;
      for (int i = 0; i < 4; i++) t2[i] <= '0;
      for (int i = 0; i < 2; i++) t3[i] <= '0;
      acc <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        t1[i] <= 33'(p[2*i]) + 33'(p[2*i+1]);
      for (int i = 0; i < 4; i++)
        t2[i] <= 34'(t1[2*i]) + 34'(t1[2*i+1]);
      for (int i = 0; i < 2; i++)
        t3[i] <= 35'(t2[2*i]) + 35'(t2[2*i+1]);
      acc <= 36'(t3[0]) + 36'(t3[1]);
    end
  end

`ifdef FIR_SAT_EN
  logic signed [35:0] sh;

  // Floor-shift back to Q1.15 and clamp
  always_comb begin
    sh = acc >>> 15;
    if (sh > 36'sd32767)
      y_next = 16'sh7FFF;
    else if (sh < -36'sd32768)
      y_next = 16'sh8000;
    else
      y_next = sh[15:0];
  end
`else
  // Floor-shift back to Q1.15, wrapping
  always_comb begin
    y_next = 16'(acc >>> 15);
  end
`endif

  // Output register
  always_ff @(posedge clk) begin
    if (rst) y_out <= '0;
    else     y_out <= y_next;
  end

endmodule

// File: tb/tb_fir_16tap.sv
// Self-checking bench for fir_16tap.
// Scoreboard queue holds expected y_out after each clock edge.
module tb_fir_16tap;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_out;

  int checks   = 0;
  int failures = 0;

  int hist [16];
  logic signed [15:0] exp_q [$];
  int cf [16] = '{512, 1024, 2048, 4096, 8192, 4096, 2048, 1024,
                  512, 256, 128, 64, 32, 16, 8, 4};

  fir_16tap dut (
    .clk   (clk),
    .rst   (rst),
    .x_in  (x_in),
    .y_out (y_out)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] model();
    longint s = 0;
    for (int i = 0; i < 16; i++)
      s += longint'(hist[i]) * longint'(cf[i]);
    s = s >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic drive(input logic signed [15:0] x, input logic r);
    x_in = x;
    rst  = r;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 16; i++) hist[i] = 0;
      exp_q.delete();
      repeat (8) exp_q.push_back(16'sd0);
    end else begin
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(x);
      exp_q.push_back(model());
    end
  endtask

  task automatic test_reset();
    logic signed [15:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(16'($urandom), 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (y_out !== 16'sd0 || y_out !== e) begin
        failures++;
        $display("FAIL reset_hold got=%0d want=0", y_out);
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(16'sd0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (y_out !== 16'sd0 || y_out !== e) begin
        failures++;
        $display("FAIL reset_after[%0d] got=%0d want=0", i, y_out);
      end
    end
  endtask

  task automatic test_impulse();
    logic signed [15:0] e;
    int imp [17] = '{256, 512, 1024, 2048, 4096, 2048, 1024, 512,
                     256, 128, 64, 32, 16, 8, 4, 2, 0};
    for (int i = 0; i < 24; i++) begin
      drive(16'sd0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (y_out !== e) begin
        failures++;
        $display("FAIL imp_pre got=%0d want=%0d", y_out, e);
      end
    end
    for (int i = 0; i < 26; i++) begin
      drive((i == 0) ? 16'sd16384 : 16'sd0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (y_out !== e) begin
        failures++;
        $display("FAIL imp_sb[%0d] got=%0d want=%0d", i, y_out, e);
      end
      if (i >= 7 && i <= 23) begin
        checks++;
        if (y_out !== 16'(imp[i-7])) begin
          failures++;
          $display("FAIL imp_tab[%0d] got=%0d want=%0d",
                   i, y_out, imp[i-7]);
        end
      end
    end
  endtask

  task automatic test_neg_floor();
    logic signed [15:0] e;
    logic signed [15:0] w;
    for (int i = 0; i < 26; i++) begin
      drive((i == 0) ? -16'sd1 : 16'sd0, 1'b0);
      e = exp_q.pop_front();
      w = (i >= 7 && i <= 22) ? -16'sd1 : 16'sd0;
      checks++;
      if (y_out !== e || y_out !== w) begin
        failures++;
        $display("FAIL neg_floor[%0d] got=%0d want=%0d sb=%0d",
                 i, y_out, w, e);
      end
    end
  endtask

  task automatic test_dc(input logic signed [15:0] x,
                         input logic signed [15:0] want);
    logic signed [15:0] e;
    for (int i = 0; i < 26; i++) begin
      drive(x, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (y_out !== e) begin
        failures++;
        $display("FAIL dc_sb x=%0d got=%0d want=%0d", x, y_out, e);
      end
    end
    checks++;
    if (y_out !== want) begin
      failures++;
      $display("FAIL dc_steady x=%0d got=%0d want=%0d", x, y_out, want);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] e;
    for (int i = 0; i < 24; i++) begin
      drive(16'sd16384, 1'b0);
      void'(exp_q.pop_front());
    end
    drive(16'sd16384, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (y_out !== 16'sd0 || y_out !== e) begin
      failures++;
      $display("FAIL mid_reset got=%0d want=0", y_out);
    end
    for (int i = 1; i <= 26; i++) begin
      drive(16'sd16384, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (y_out !== e) begin
        failures++;
        $display("FAIL mid_sb[%0d] got=%0d want=%0d", i, y_out, e);
      end
      if (i <= 7 || i == 8 || i == 9 || i == 26) begin
        logic signed [15:0] w;
        w = (i <= 7) ? 16'sd0 : (i == 8) ? 16'sd256 :
            (i == 9) ? 16'sd768 : 16'sd12030;
        checks++;
        if (y_out !== w) begin
          failures++;
          $display("FAIL mid_step[%0d] got=%0d want=%0d", i, y_out, w);
        end
      end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] e;
    for (int i = 0; i < 48; i++) begin
      drive(16'($urandom), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (y_out !== e) begin
        failures++;
        $display("FAIL random[%0d] got=%0d want=%0d", i, y_out, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(16'sd0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (y_out !== e) begin
        failures++;
        $display("FAIL rand_flush[%0d] got=%0d want=%0d", i, y_out, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) hist[i] = 0;
    test_reset();
    test_impulse();
    test_neg_floor();
    test_dc(16'sd32767, 16'sd24059);
    test_dc(-16'sd32768, -16'sd24060);
    test_dc(16'sd16384, 16'sd12030);
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
